dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the core load/store path, port 1 is the DMA/debug path.
- Accepts one request at a time through a valid/ready handshake and sequences it onto the memory's rd_en/wr_en/addr/wdata2/func3 interface.
- Returns a registered response carrying read data, or an error, to the requester that won.
- Sits between the LSU/DMA and data_mem; data_mem itself is unchanged.

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arb_pick.sv | 27 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned NUM_PORTS = 2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_t;

   function automatic logic is_legal(input logic we, input logic [2:0] func3);
      logic ok;
      ok = 1'b0;
      if (we) begin
         ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
      end else begin
         ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
              (func3 == F3_BU) || (func3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant select. DMEM_ARB_RR_EN selects round-robin, otherwise
// port 0 has fixed priority.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] i_req_valid,
   input  logic                 i_last_grant,
   output logic                 o_any,
   output logic                 o_grant
);

   always_comb begin
      o_any = |i_req_valid;
      unique case (i_req_valid)
         2'b01:   o_grant = 1'b0;
         2'b10:   o_grant = 1'b1;
`ifdef DMEM_ARB_RR_EN
         2'b11:   o_grant = ~i_last_grant;
`else
         2'b11:   o_grant = 1'b0;
`endif
         // Nothing pending: park on the previous winner, the value is unused.
         default: o_grant = i_last_grant;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: IDLE -> ACCESS -> RESP.
// Arbitration policy is chosen by DMEM_ARB_RR_EN inside dmem_arb_pick.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_WORDS = 100
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0]                req_valid,
   output logic [NUM_PORTS-1:0]                req_ready,
   input  logic [NUM_PORTS-1:0]                req_we,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]    req_wdata,
   input  logic [NUM_PORTS-1:0][2:0]           req_func3,
   output logic [NUM_PORTS-1:0]                resp_valid,
   output logic [DATA_W-1:0]                   resp_rdata,
   output logic                                resp_err,
   output logic                                mem_rd_en,
   output logic                                mem_wr_en,
   output logic [ADDR_W-1:0]                   mem_addr,
   output logic [DATA_W-1:0]                   mem_wdata,
   output logic [2:0]                          mem_func3,
   input  logic [DATA_W-1:0]                   mem_rdata
);

   localparam logic [ADDR_W-3:0] LP_MEM_WORDS = (ADDR_W-2)'(MEM_WORDS);

   state_t              r_state, w_state_next;
   logic                r_last_grant, r_g, r_we, r_err;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata, r_rdata;
   logic [2:0]          r_func3;

   logic                w_any, w_grant, w_hs, w_err;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [2:0]          w_sel_func3;

   dmem_arb_pick u_pick (
      .i_req_valid  (req_valid),
      .i_last_grant (r_last_grant),
      .o_any        (w_any),
      .o_grant      (w_grant)
   );

   assign w_hs        = (r_state == StIdle) && w_any;
   assign w_sel_we    = req_we[w_grant];
   assign w_sel_addr  = req_addr[w_grant];
   assign w_sel_func3 = req_func3[w_grant];

   always_comb begin
      w_err = !is_legal(w_sel_we, w_sel_func3);
      if ((w_sel_func3[1:0] == 2'b01) && w_sel_addr[0]) begin
         w_err = 1'b1;
      end
      if ((w_sel_func3[1:0] == 2'b10) && (w_sel_addr[1:0] != 2'b00)) begin
         w_err = 1'b1;
      end
      if (w_sel_addr[ADDR_W-1:2] >= LP_MEM_WORDS) begin
         w_err = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      resp_valid   = '0;
      resp_err     = 1'b0;
      resp_rdata   = '0;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_func3    = 3'b000;
      unique case (r_state)
         StIdle: begin
            if (w_any) begin
               req_ready[w_grant] = 1'b1;
               w_state_next       = StAccess;
            end
         end
         StAccess: begin
            mem_addr     = r_addr;
            mem_wdata    = r_wdata;
            mem_func3    = r_func3;
            mem_rd_en    = !r_we && !r_err;
            mem_wr_en    = r_we && !r_err;
            w_state_next = StResp;
         end
         StResp: begin
            resp_valid[r_g] = 1'b1;
            resp_err        = r_err;
            resp_rdata      = r_rdata;
            w_state_next    = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_last_grant <= 1'b1;
         r_g          <= 1'b0;
         r_we         <= 1'b0;
         r_err        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_func3      <= 3'b000;
         r_rdata      <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_hs) begin
            r_g          <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= req_wdata[w_grant];
            r_func3      <= w_sel_func3;
            r_err        <= w_err;
         end
         // Stores and errored accesses report zero data.
         if (r_state == StAccess) begin
            r_rdata <= (!r_we && !r_err) ? mem_rdata : '0;
         end
      end
   end

endmodule
